wb_bus_arbiter: RTL
===================

# wb_bus_arbiter

Two-master Wishbone (pipelined) arbiter that shares the CPU's single external bus port between the instruction-fetch unit (master 0) and the load/store memory unit (master 1). It sits between those two units and the SoC interconnect, and guarantees that exactly one unit drives o_wb_* at any time. A per-grant watchdog terminates hung transactions with an error pulse.

## Interface
- AW, 32, address width
- DW, 32, data width
- TIMEOUT, 255, max cycles a granted master waits for an ack with a transaction outstanding (1..255)
- clk  in  1  clock
- reset  in  1  synchronous, active-low
- i_m0_cyc, i_m0_stb, i_m0_we  in  1 each  master 0 (fetch) bus request
- i_m0_addr  in  AW;  i_m0_data  in  DW
- o_m0_data  out  DW;  o_m0_ack, o_m0_stall, o_m0_err  out  1 each
- i_m1_cyc, i_m1_stb, i_m1_we  in  1 each  master 1 (load/store) bus request
- i_m1_addr  in  AW;  i_m1_data  in  DW
- o_m1_data  out  DW;  o_m1_ack, o_m1_stall, o_m1_err  out  1 each
- o_wb_cyc, o_wb_stb, o_wb_we  out  1 each  downstream bus
- o_wb_addr  out  AW;  o_wb_data  out  DW
- i_wb_data  in  DW;  i_wb_ack, i_wb_stall  in  1 each

## Operation
- States: IDLE, GNT0, GNT1 (registered). last_grant flag (registered) for round-robin.
- IDLE: nothing driven downstream. If only one i_mX_cyc high -> GNTX. If both high -> grant the master not equal to last_grant.
- GNTX: o_wb_cyc/stb/we/addr/data = master X's inputs (combinational mux); o_mX_stall = i_wb_stall; o_mX_ack = i_wb_ack; o_mX_data = i_wb_data. last_grant <= X on entry.
- Non-granted master: stall = 1, ack = 0, err = 0; its o_data is don't-care, driven 0.
- Release: granted master drops cyc -> if the other master's cyc is high, switch directly to its grant next cycle; else IDLE. No mid-cycle preemption: a grant persists while cyc stays high.
- Outstanding counter (4 bits, saturating at 15): +1 on o_wb_stb & ~i_wb_stall, -1 on i_wb_ack; simultaneous accept and ack -> unchanged. Cleared on every grant change.
- Watchdog (8 bits): counts while granted, outstanding > 0, and no ack; cleared on ack or grant change. On reaching TIMEOUT: o_mX_err = 1 for one cycle, o_wb_cyc forced 0 for that cycle, state -> IDLE, outstanding cleared. The master must drop cyc on err; if it keeps cyc high it is re-arbitrated normally from IDLE.
- An ack arriving while outstanding = 0 (stray) is forwarded to the granted master but does not decrement below 0.

## Timing
- Reset (reset = 0 sampled at clk edge): state IDLE, last_grant = 1 (so m0 wins the first tie), counters 0. Outputs after reset: o_wb_cyc/stb/we = 0, o_wb_addr/data = 0, o_mX_ack/err = 0, o_mX_stall = 1, o_mX_data = 0.
- Reset mid-transaction: o_wb_cyc falls in the cycle after reset is sampled; in-flight acks are dropped.
- Arbitration latency: 1 cycle (cyc rising in cycle N -> o_wb_cyc high in N+1). Master is stalled in cycle N.
- Handover: cyc drop in cycle N -> other master owns bus in N+1; o_wb_cyc is low for at least that boundary edge only if no waiter (no mandatory idle cycle).
- Ack/stall/data pass-through: zero latency (combinational).
- Err: asserted in the cycle the watchdog equals TIMEOUT, i.e. TIMEOUT cycles after the last ack/accept with outstanding > 0.

## Test plan
- Single master: m0 reads 0xb0000000, slave acks after 2 cycles with 0x1234abcd -> o_wb_cyc high one cycle after i_m0_cyc, o_m0_data = 0x1234abcd with o_m0_ack, m1 stall = 1 throughout.
- Tie after reset: both cyc rise same cycle -> m0 granted first; m0 drops cyc -> m1 granted next cycle with no idle gap; next tie -> m1 loses to m0 only if last_grant = 1 (alternation checked over 4 ties).
- Pipelined burst: m1 issues 3 stbs with i_wb_stall high on the 2nd -> 3 accepts, outstanding peaks at 3, returns 0 after 3 acks; m0 stays stalled until m1 drops cyc.
- Timeout: TIMEOUT = 8, m0 issues one stb, slave never acks -> o_m0_err pulses exactly 8 cycles after accept, o_wb_cyc low that cycle, state IDLE next.
- Reset mid-operation: reset low while GNT1 with 2 outstanding -> next cycle all outputs at reset values, both stalls = 1; after release m0 wins the first tie.
- Stray ack in GNT0 with outstanding 0 -> forwarded to m0, counter stays 0, no err.

Source files
------------

// File: rtl/wb_bus_arbiter_if.sv
// rtl/wb_bus_arbiter_if.sv - pipelined Wishbone bus bundle shared by the arbiter's upstream and downstream ports
//
// Parameters: AW address width, DW data width.
// Signals: cyc/stb/we/addr/wdata travel master -> slave; rdata/ack/stall/err travel slave -> master.
// master modport: the side that issues cycles (the arbiter's downstream port; it has no err input).
// slave modport: the side that answers cycles (the arbiter's port towards each requesting unit).
interface wb_bus_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          cyc;
    logic          stb;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          ack;
    logic          stall;
    logic          err;

    modport master (
        output cyc, stb, we, addr, wdata,
        input  rdata, ack, stall
    );

    modport slave (
        input  cyc, stb, we, addr, wdata,
        output rdata, ack, stall, err
    );
endinterface

// File: rtl/wb_bus_arbiter.sv
// rtl/wb_bus_arbiter.sv - two-master pipelined Wishbone arbiter with per-grant watchdog
//
// Parameters: AW address width, DW data width, TIMEOUT cycles (1..255) a granted master may wait
//             for an ack while it has a transaction outstanding.
// Ports:
//   clk    clock
//   reset  synchronous, active-low
//   m0     instruction-fetch unit (slave side of its bus)
//   m1     load/store unit (slave side of its bus)
//   wb     shared downstream bus (master side)
module wb_bus_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    wb_bus_arbiter_if.slave       m0,
    wb_bus_arbiter_if.slave       m1,
    wb_bus_arbiter_if.master      wb
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    // The watchdog fires in the cycle whose count would reach TIMEOUT, so compare against TIMEOUT-1.
    localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

    state_t        state;
    state_t        state_next;
    logic          last_grant;
    logic [3:0]    outstanding;
    logic [7:0]    wdog;

    logic          granted;
    logic          grant_change;
    logic          sel_cyc;
    logic          sel_stb;
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;
    logic          ack_in;
    logic          accept;
    logic          wd_count;
    logic          timeout_hit;

    logic          bus_cyc;
    logic          bus_stb;
    logic          bus_we;
    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_wdata;
    logic          m0_ack;
    logic          m0_stall;
    logic          m0_err;
    logic [DW-1:0] m0_rdata;
    logic          m1_ack;
    logic          m1_stall;
    logic          m1_err;
    logic [DW-1:0] m1_rdata;

    assign granted   = (state == GNT0) || (state == GNT1);
    assign sel_cyc   = (state == GNT1) ? m1.cyc   : m0.cyc;
    assign sel_stb   = (state == GNT1) ? m1.stb   : m0.stb;
    assign sel_we    = (state == GNT1) ? m1.we    : m0.we;
    assign sel_addr  = (state == GNT1) ? m1.addr  : m0.addr;
    assign sel_wdata = (state == GNT1) ? m1.wdata : m0.wdata;

    // Acks seen while idle (e.g. stragglers after a reset) never touch the bookkeeping.
    assign ack_in      = granted & wb.ack;
    assign accept      = bus_stb & ~wb.stall;
    assign wd_count    = granted && (outstanding != 4'd0) && !wb.ack;
    assign timeout_hit = wd_count && (wdog == WD_LAST);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (m0.cyc && m1.cyc) begin
                    state_next = last_grant ? GNT0 : GNT1;
                end else if (m0.cyc) begin
                    state_next = GNT0;
                end else if (m1.cyc) begin
                    state_next = GNT1;
                end
            end
            GNT0: begin
                if (timeout_hit) begin
                    state_next = IDLE;
                end else if (!m0.cyc) begin
                    state_next = m1.cyc ? GNT1 : IDLE;
                end
            end
            GNT1: begin
                if (timeout_hit) begin
                    state_next = IDLE;
                end else if (!m1.cyc) begin
                    state_next = m0.cyc ? GNT0 : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign grant_change = (state_next != state);

    always_ff @(posedge clk) begin
        if (!reset) begin
            last_grant  <= 1'b1;
            outstanding <= 4'd0;
            wdog        <= 8'd0;
        end else if (grant_change) begin
            outstanding <= 4'd0;
            wdog        <= 8'd0;
            if (state_next == GNT0) begin
                last_grant <= 1'b0;
            end else if (state_next == GNT1) begin
                last_grant <= 1'b1;
            end
        end else begin
            if (accept && !ack_in) begin
                if (outstanding != 4'd15) begin
                    outstanding <= outstanding + 4'd1;
                end
            end else if (ack_in && !accept) begin
                if (outstanding != 4'd0) begin
                    outstanding <= outstanding - 4'd1;
                end
            end
            if (ack_in) begin
                wdog <= 8'd0;
            end else if (wd_count) begin
                wdog <= wdog + 8'd1;
            end
        end
    end

    always_comb begin
        bus_cyc   = 1'b0;
        bus_stb   = 1'b0;
        bus_we    = 1'b0;
        bus_addr  = '0;
        bus_wdata = '0;
        m0_ack    = 1'b0;
        m0_stall  = 1'b1;
        m0_err    = 1'b0;
        m0_rdata  = '0;
        m1_ack    = 1'b0;
        m1_stall  = 1'b1;
        m1_err    = 1'b0;
        m1_rdata  = '0;
        if (granted) begin
            // The timeout cycle drops the bus so the slave sees the hung cycle abandoned.
            bus_cyc   = sel_cyc & ~timeout_hit;
            bus_stb   = sel_cyc & sel_stb & ~timeout_hit;
            bus_we    = sel_we;
            bus_addr  = sel_addr;
            bus_wdata = sel_wdata;
        end
        // Stall is held high in the timeout cycle so the master does not count a strobe the bus never saw.
        if (state == GNT0) begin
            m0_ack   = wb.ack;
            m0_stall = wb.stall | timeout_hit;
            m0_err   = timeout_hit;
            m0_rdata = wb.rdata;
        end
        if (state == GNT1) begin
            m1_ack   = wb.ack;
            m1_stall = wb.stall | timeout_hit;
            m1_err   = timeout_hit;
            m1_rdata = wb.rdata;
        end
    end

    assign wb.cyc   = bus_cyc;
    assign wb.stb   = bus_stb;
    assign wb.we    = bus_we;
    assign wb.addr  = bus_addr;
    assign wb.wdata = bus_wdata;
    assign m0.ack   = m0_ack;
    assign m0.stall = m0_stall;
    assign m0.err   = m0_err;
    assign m0.rdata = m0_rdata;
    assign m1.ack   = m1_ack;
    assign m1.stall = m1_stall;
    assign m1.err   = m1_err;
    assign m1.rdata = m1_rdata;
endmodule
